alu_vec_checker: RTL and testbench

ALU_VEC_CHECKER -- requirements
Module: alu_vec_checker

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 45 ++++
 rtl/alu_vec_checker.sv | 148 ++++++++++++++
 tb/tb_alu_vec_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and stage-1 vector record for the ALU vector checker.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_BEQ = 4'b1001;
  localparam logic [3:0] ALU_BNE = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        last;
    logic        alu_src;
    logic [3:0]  ctrl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [31:0] exp_result;
    logic        exp_ovf;
  } vec_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; overflow is carry-out for ADD and borrow for SUB.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        overflow
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit 32 of the zero-extended difference is set exactly when a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result   = sum[31:0];
        overflow = sum[32];
      end
      ALU_SUB: begin
        result   = diff[31:0];
        overflow = diff[32];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = {31'd0, (a < b)};
      ALU_BEQ: result = {31'd0, (a == b)};
      ALU_BNE: result = {31'd0, (a != b)};
      default: begin
        result   = 32'd0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_vec_checker.sv
// Checks ALU test vectors against expected result/overflow; outcome 2 cycles after accept.
// vecReady is high only in RUN and drops while the vecLast vector is in flight.
module alu_vec_checker
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vecValid,
  output logic             vecReady,
  input  logic             vecLast,
  input  logic             vecAluSrc,
  input  logic [31:0]      vecData1,
  input  logic [31:0]      vecData2,
  input  logic [31:0]      vecImm,
  input  logic [3:0]       vecAluCtrl,
  input  logic [31:0]      vecExpResult,
  input  logic             vecExpOverflow,
  output logic             chkValid,
  output logic             chkPass,
  output logic [CNT_W-1:0] passCount,
  output logic [CNT_W-1:0] failCount,
  output logic [CNT_W-1:0] firstFailIdx,
  output logic [31:0]      firstFailGot,
  output logic             busy,
  output logic             done
);

  state_t state, state_nxt;

  vec_t             vec_in;
  vec_t             s1;
  logic             s1_vld;
  logic [CNT_W-1:0] s1_idx;
  logic [CNT_W-1:0] vec_idx;
  logic             has_failed;
  logic             accept;
  logic [31:0]      operand2;
  logic [31:0]      alu_result;
  logic             alu_ovf;
  logic             s1_pass;

  assign vec_in = '{
    last:       vecLast,
    alu_src:    vecAluSrc,
    ctrl:       vecAluCtrl,
    data1:      vecData1,
    data2:      vecData2,
    imm:        vecImm,
    exp_result: vecExpResult,
    exp_ovf:    vecExpOverflow
  };

  assign accept   = vecValid && vecReady;
  assign operand2 = s1.alu_src ? s1.imm : s1.data2;

  alu u_alu (
    .a        (s1.data1),
    .b        (operand2),
    .ctrl     (s1.ctrl),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  assign s1_pass = (alu_result == s1.exp_result) && (alu_ovf == s1.exp_ovf);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vecReady  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        vecReady = !(s1_vld && s1.last);
        // A restart wins over the completion of the final vector.
        if (!start && s1_vld && s1.last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '0;
      s1_vld       <= 1'b0;
      s1_idx       <= '0;
      vec_idx      <= '0;
      chkValid     <= 1'b0;
      chkPass      <= 1'b0;
      passCount    <= '0;
      failCount    <= '0;
      firstFailIdx <= '0;
      firstFailGot <= 32'd0;
      has_failed   <= 1'b0;
    end else begin
      chkValid <= 1'b0;
      chkPass  <= 1'b0;
      s1_vld   <= accept;
      if (accept) s1 <= vec_in;

      if (start) begin
        // Flush the in-flight check; a vector handshaken now opens the new run at index 0.
        passCount    <= '0;
        failCount    <= '0;
        firstFailIdx <= '0;
        firstFailGot <= 32'd0;
        has_failed   <= 1'b0;
        s1_idx       <= '0;
        vec_idx      <= CNT_W'(accept);
      end else begin
        if (accept) begin
          s1_idx  <= vec_idx;
          vec_idx <= vec_idx + 1'b1;
        end
        if (s1_vld) begin
          chkValid <= 1'b1;
          chkPass  <= s1_pass;
          if (s1_pass) begin
            if (passCount != {CNT_W{1'b1}}) passCount <= passCount + 1'b1;
          end else begin
            if (failCount != {CNT_W{1'b1}}) failCount <= failCount + 1'b1;
            if (!has_failed) begin
              has_failed   <= 1'b1;
              firstFailIdx <= s1_idx;
              firstFailGot <= alu_result;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_vec_checker.sv
// Self-checking bench: directed table, hand sequences and random runs against a queue-based model.
module tb_alu_vec_checker;

  localparam int CNT_W = 4;

  logic             clk, rst, start;
  logic             vecValid, vecReady, vecLast, vecAluSrc;
  logic [31:0]      vecData1, vecData2, vecImm, vecExpResult;
  logic [3:0]       vecAluCtrl;
  logic             vecExpOverflow;
  logic             chkValid, chkPass;
  logic [CNT_W-1:0] passCount, failCount, firstFailIdx;
  logic [31:0]      firstFailGot;
  logic             busy, done;

  alu_vec_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vecValid(vecValid), .vecReady(vecReady), .vecLast(vecLast),
    .vecAluSrc(vecAluSrc), .vecData1(vecData1), .vecData2(vecData2),
    .vecImm(vecImm), .vecAluCtrl(vecAluCtrl), .vecExpResult(vecExpResult),
    .vecExpOverflow(vecExpOverflow), .chkValid(chkValid), .chkPass(chkPass),
    .passCount(passCount), .failCount(failCount), .firstFailIdx(firstFailIdx),
    .firstFailGot(firstFailGot), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        last;
    logic        src;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, imm, exp_r;
    logic        exp_o;
  } tvec_t;

  typedef struct {
    logic             pass;
    logic [31:0]      got;
    logic [CNT_W-1:0] idx;
    logic             last;
  } flight_t;

  typedef struct {
    string name;
    tvec_t v;
    logic  exp_pass;
  } tbl_t;

  int n_checks, n_fail;

  // Model: 0 idle, 1 run, 2 done; fq holds accepted vectors whose outcome is not yet visible.
  int               m_st;
  flight_t          fq[$];
  logic             m_chk_vld, m_chk_pass, m_in_reset, m_failed;
  logic [CNT_W-1:0] m_pass, m_fail, m_ffidx, m_idx;
  logic [31:0]      m_ffgot;

  int   seen_chk;
  logic seen_pass;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
    logic [32:0] w;
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'b0000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; v = w[32]; end
      4'b0010: begin r = a - b; v = (a < b); end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a << b[4:0];
      4'b0111: r = a >> b[4:0];
      4'b1000: r = (a < b) ? 32'd1 : 32'd0;
      4'b1001: r = (a == b) ? 32'd1 : 32'd0;
      4'b1010: r = (a != b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; v = 1'b0; end
    endcase
  endfunction

  function automatic tvec_t mk(input logic [3:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                               input logic src, input logic [31:0] imm, input logic [31:0] exp_r,
                               input logic exp_o, input logic last);
    tvec_t t;
    t.ctrl = ctrl; t.d1 = d1; t.d2 = d2; t.src = src; t.imm = imm;
    t.exp_r = exp_r; t.exp_o = exp_o; t.last = last;
    return t;
  endfunction

  function automatic tvec_t nop();
    return mk(4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endfunction

  task automatic model_reset();
    m_st = 0; fq.delete();
    m_chk_vld = 0; m_chk_pass = 0; m_in_reset = 1; m_failed = 0;
    m_pass = '0; m_fail = '0; m_ffidx = '0; m_idx = '0; m_ffgot = 32'd0;
  endtask

  // One clock cycle: drive inputs, compare outputs of the previous edge, advance the model.
  task automatic step(input logic r, input logic s, input logic v, input tvec_t x);
    logic        m_ready, acc, pass, o;
    logic [31:0] res;
    flight_t     f;
    rst = r; start = s; vecValid = v;
    vecLast = x.last; vecAluSrc = x.src; vecAluCtrl = x.ctrl;
    vecData1 = x.d1; vecData2 = x.d2; vecImm = x.imm;
    vecExpResult = x.exp_r; vecExpOverflow = x.exp_o;

    m_ready = (m_st == 1) && !(fq.size() > 0 && fq[0].last);
    check("chkValid", chkValid, m_chk_vld);
    if (m_chk_vld || m_in_reset) check("chkPass", chkPass, m_chk_pass);
    check("vecReady", vecReady, m_ready);
    check("busy", busy, m_st == 1);
    check("done", done, m_st == 2);
    check("passCount", passCount, m_pass);
    check("failCount", failCount, m_fail);
    check("firstFailIdx", firstFailIdx, m_ffidx);
    check("firstFailGot", firstFailGot, m_ffgot);
    if (chkValid === 1'b1) begin
      seen_chk++;
      seen_pass = chkPass;
    end

    acc = v && m_ready;
    if (r) begin
      model_reset();
    end else begin
      m_in_reset = 0; m_chk_vld = 0; m_chk_pass = 0;
      if (s) begin
        fq.delete(); m_st = 1; m_idx = '0; m_failed = 0;
        m_pass = '0; m_fail = '0; m_ffidx = '0; m_ffgot = 32'd0;
      end else if (fq.size() > 0) begin
        f = fq.pop_front();
        m_chk_vld = 1; m_chk_pass = f.pass;
        if (f.pass) begin
          if (m_pass != '1) m_pass++;
        end else begin
          if (m_fail != '1) m_fail++;
          if (!m_failed) begin m_failed = 1; m_ffidx = f.idx; m_ffgot = f.got; end
        end
        if (f.last) m_st = 2;
      end
      if (acc) begin
        ref_alu(x.ctrl, x.d1, x.src ? x.imm : x.d2, res, o);
        pass = (res == x.exp_r) && (o == x.exp_o);
        fq.push_back('{pass: pass, got: res, idx: m_idx, last: x.last});
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, nop());
  endtask

  tbl_t tbl[14];

  initial begin
    n_checks = 0; n_fail = 0; seen_chk = 0; seen_pass = 0;
    rst = 1; start = 0; vecValid = 0; vecLast = 0; vecAluSrc = 0; vecAluCtrl = 0;
    vecData1 = 0; vecData2 = 0; vecImm = 0; vecExpResult = 0; vecExpOverflow = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    tbl[0]  = '{"add_3_5",    mk(4'b0000, 32'd3, 32'd5, 0, 0, 32'd8, 0, 1), 1'b1};
    tbl[1]  = '{"sub_15_5",   mk(4'b0010, 32'd15, 32'd5, 0, 0, 32'd10, 0, 1), 1'b1};
    tbl[2]  = '{"add_carry",  mk(4'b0000, 32'hFFAA123E, 32'hDD1111B1, 0, 0, 32'hDCBB23EF, 1, 1), 1'b1};
    tbl[3]  = '{"add_ovf_mis", mk(4'b0000, 32'hFFAA123E, 32'hDD1111B1, 0, 0, 32'hDCBB23EF, 0, 1), 1'b0};
    tbl[4]  = '{"and",        mk(4'b0100, 32'hF0F0F0F1, 32'h0F0F0F0F, 0, 0, 32'h00000001, 0, 1), 1'b1};
    tbl[5]  = '{"or_imm",     mk(4'b0101, 32'hF0F0F0F1, 32'd0, 1, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 1), 1'b1};
    tbl[6]  = '{"sll_31",     mk(4'b0110, 32'd1, 32'd31, 0, 0, 32'h80000000, 0, 1), 1'b1};
    tbl[7]  = '{"srl_mask",   mk(4'b0111, 32'h80000000, 32'd35, 0, 0, 32'h10000000, 0, 1), 1'b1};
    tbl[8]  = '{"slt_uns",    mk(4'b1000, 32'd1, 32'hFFFFFFFF, 0, 0, 32'd1, 0, 1), 1'b1};
    tbl[9]  = '{"beq",        mk(4'b1001, 32'd7, 32'd7, 0, 0, 32'd1, 0, 1), 1'b1};
    tbl[10] = '{"bne",        mk(4'b1010, 32'd7, 32'd7, 0, 0, 32'd0, 0, 1), 1'b1};
    tbl[11] = '{"sub_borrow", mk(4'b0010, 32'd5, 32'd15, 0, 0, 32'hFFFFFFF6, 1, 1), 1'b1};
    tbl[12] = '{"op_undef",   mk(4'b0011, 32'd9, 32'd9, 0, 0, 32'd0, 0, 1), 1'b1};
    tbl[13] = '{"op_undef_nz", mk(4'b1111, 32'd2, 32'd3, 0, 0, 32'd5, 0, 1), 1'b0};

    idle(1);

    // Reset while a vector is in flight must not produce an outcome.
    step(0, 1, 0, nop());
    step(0, 0, 1, mk(4'b0000, 32'd3, 32'd5, 0, 0, 32'd8, 0, 0));
    seen_chk = 0;
    step(1, 0, 0, nop());
    idle(3);
    check("no_chk_after_rst", seen_chk, 0);

    // Two-vector run ending in DONE.
    step(0, 1, 0, nop());
    step(0, 0, 1, mk(4'b0000, 32'd3, 32'd5, 0, 0, 32'd8, 0, 0));
    step(0, 0, 1, mk(4'b0010, 32'd15, 32'd5, 0, 0, 32'd10, 0, 1));
    idle(3);
    check("run1_pass", passCount, 2);
    check("run1_done", done, 1);

    // First-fail capture is not overwritten by a later failure.
    step(0, 1, 0, nop());
    step(0, 0, 1, mk(4'b0000, 32'hFFAA123E, 32'hDD1111B1, 0, 0, 32'hDCBB23EF, 0, 0));
    step(0, 0, 1, mk(4'b0000, 32'd1, 32'd1, 0, 0, 32'd3, 0, 1));
    idle(3);
    check("fail_cnt", failCount, 2);
    check("fail_idx", firstFailIdx, 0);
    check("fail_got", firstFailGot, 32'hDCBB23EF);

    // Back-to-back AND then OR-with-immediate.
    step(0, 1, 0, nop());
    seen_chk = 0;
    step(0, 0, 1, mk(4'b0100, 32'hF0F0F0F1, 32'h0F0F0F0F, 0, 0, 32'h00000001, 0, 0));
    step(0, 0, 1, mk(4'b0101, 32'hF0F0F0F1, 32'd0, 1, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 1));
    idle(3);
    check("b2b_chk", seen_chk, 2);
    check("b2b_pass", passCount, 2);

    // Restart one cycle after an accept flushes it.
    step(0, 1, 0, nop());
    step(0, 0, 1, mk(4'b0000, 32'd3, 32'd5, 0, 0, 32'd8, 0, 0));
    seen_chk = 0;
    step(0, 1, 0, nop());
    idle(3);
    check("flush_chk", seen_chk, 0);
    check("flush_pass", passCount, 0);
    check("flush_fail", failCount, 0);
    check("flush_busy", busy, 1);

    // Saturation of passCount and index wrap at 16.
    step(0, 1, 0, nop());
    for (int i = 0; i < 17; i++) step(0, 0, 1, mk(4'b0000, 32'd1, 32'd1, 0, 0, 32'd2, 0, 0));
    step(0, 0, 1, mk(4'b0000, 32'd1, 32'd1, 0, 0, 32'd0, 0, 1));
    idle(4);
    check("sat_pass", passCount, 15);
    check("sat_fail", failCount, 1);
    check("wrap_idx", firstFailIdx, 1);
    check("wrap_got", firstFailGot, 2);
    idle(2);
    check("sat_hold", passCount, 15);

    foreach (tbl[k]) begin
      step(0, 1, 0, nop());
      seen_chk = 0;
      seen_pass = 1'bx;
      step(0, 0, 1, tbl[k].v);
      idle(3);
      check({"tbl_cnt_", tbl[k].name}, seen_chk, 1);
      check({"tbl_", tbl[k].name}, seen_pass, tbl[k].exp_pass);
    end

    for (int i = 0; i < 1500; i++) begin
      tvec_t       x;
      logic [31:0] r32;
      logic        o, r, s;
      logic [3:0]  ops[10];
      ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
              4'b1000, 4'b1001, 4'b1010, 4'b0000};
      ops[9] = 4'($urandom_range(0, 15));
      x.ctrl = ops[$urandom_range(0, 9)];
      x.d1 = $urandom;
      x.d2 = ($urandom_range(0, 3) == 0) ? x.d1 : $urandom;
      x.imm = $urandom;
      x.src = 1'($urandom_range(0, 1));
      x.last = ($urandom_range(0, 9) == 0);
      ref_alu(x.ctrl, x.d1, x.src ? x.imm : x.d2, r32, o);
      case ($urandom_range(0, 3))
        0: r32 = r32 ^ (32'd1 << $urandom_range(0, 31));
        1: o = ~o;
        default: ;
      endcase
      x.exp_r = r32;
      x.exp_o = o;
      r = ($urandom_range(0, 299) == 0);
      s = (m_st != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      step(r, s, ($urandom_range(0, 3) != 0), x);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
